// File: rtl/xst.sv
// rtl/xst.sv - serial shift transmitter, LSB-first with bit strobe clock
//
// Loads a word (straight or bit-reversed) and shifts it out on txd_o one bit
// every baud_i+1 clocks; txc_o rises at the start of every bit.
//
// Ports:
//   clk_i        clock, all state changes on its rising edge
//   reset_i      asynchronous active-high reset
//   bits_i       frame length N, captured when a write is accepted
//   baud_i       bit-period divisor B, captured at every bit start
//   dat_i        word to transmit
//   txreg_we_i   write strobe, straight load (wins over txregr_we_i)
//   txregr_we_i  write strobe, bit-reversed load
//   txd_o        serial data, mark level 1
//   txc_o        bit strobe clock
//   idle_o       high when no frame is in progress
//   shift_to     one-cycle pulse in the last cycle of every bit

module xst #(
    parameter int SHIFT_REG_WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [5:0]                 bits_i,
    input  logic [63:0]                baud_i,
    input  logic [SHIFT_REG_WIDTH-1:0] dat_i,
    input  logic                       txreg_we_i,
    input  logic                       txregr_we_i,
    output logic                       txd_o,
    output logic                       txc_o,
    output logic                       idle_o,
    output logic                       shift_to
);

    logic [SHIFT_REG_WIDTH-1:0] sr_q, sr_d;
    logic [SHIFT_REG_WIDTH-1:0] dat_rev;
    logic [5:0]                 bits_left_q, bits_left_d;
    logic [63:0]                ctr_q, ctr_d;
    logic                       idle;

    assign idle = (bits_left_q == 6'd0);

    always_comb begin
        dat_rev = '0;
        for (int i = 0; i < SHIFT_REG_WIDTH; i++) begin
            dat_rev[i] = dat_i[SHIFT_REG_WIDTH-1-i];
        end
    end

    always_comb begin
        sr_d        = sr_q;
        bits_left_d = bits_left_q;
        ctr_d       = ctr_q;
        if (idle) begin
            // A zero-length write still loads sr; bits_left stays 0 so no frame starts.
            if (txreg_we_i) begin
                sr_d        = dat_i;
                bits_left_d = bits_i;
                ctr_d       = baud_i;
            end else if (txregr_we_i) begin
                sr_d        = dat_rev;
                bits_left_d = bits_i;
                ctr_d       = baud_i;
            end
        end else if (ctr_q == 64'd0) begin
            // End of bit: shift in mark, reload divisor from the live baud_i.
            sr_d        = {1'b1, sr_q[SHIFT_REG_WIDTH-1:1]};
            bits_left_d = bits_left_q - 6'd1;
            ctr_d       = baud_i;
        end else begin
            ctr_d = ctr_q - 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sr_q        <= '1;
            bits_left_q <= 6'd0;
            ctr_q       <= 64'd0;
        end else begin
            sr_q        <= sr_d;
            bits_left_q <= bits_left_d;
            ctr_q       <= ctr_d;
        end
    end

    assign idle_o   = idle;
    assign txd_o    = idle ? 1'b1 : sr_q[0];
    // ctr counts B..0 within a bit, so txc_o is high for the first B-(B>>1) cycles.
    assign txc_o    = ~idle & (ctr_q > (baud_i >> 1));
    assign shift_to = ~idle & (ctr_q == 64'd0);

endmodule

// File: tb/tb_xst.sv
// tb/tb_xst.sv - self-checking bench for xst
module tb_xst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  bits_i = 6'd0;
    logic [63:0] baud_i = 64'd0;
    logic [63:0] dat_i = 64'd0;
    logic        txreg_we_i = 1'b0;
    logic        txregr_we_i = 1'b0;
    logic        txd_o, txc_o, idle_o, shift_to;

    int n_assert = 0;
    int n_fail   = 0;

    xst #(.SHIFT_REG_WIDTH(64)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .bits_i     (bits_i),
        .baud_i     (baud_i),
        .dat_i      (dat_i),
        .txreg_we_i (txreg_we_i),
        .txregr_we_i(txregr_we_i),
        .txd_o      (txd_o),
        .txc_o      (txc_o),
        .idle_o     (idle_o),
        .shift_to   (shift_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    // Frame-level model: frame in progress, current bit index, position within
    // the bit and the period length captured at the bit start.
    logic        m_busy = 1'b0;
    logic [63:0] m_word = 64'd0;
    int          m_n = 0;
    int          m_k = 0;
    logic [63:0] m_pos = 64'd0;
    logic [63:0] m_len = 64'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_pos  <= 64'd0;
        end else if (m_busy) begin
            if (m_pos == m_len) begin
                if (m_k + 1 == m_n) begin
                    m_busy <= 1'b0;
                end else begin
                    m_k   <= m_k + 1;
                    m_pos <= 64'd0;
                    m_len <= baud_i;
                end
            end else begin
                m_pos <= m_pos + 64'd1;
            end
        end else if (txreg_we_i || txregr_we_i) begin
            m_word <= txreg_we_i ? dat_i : rev64(dat_i);
            if (bits_i != 6'd0) begin
                m_busy <= 1'b1;
                m_n    <= int'(bits_i);
                m_k    <= 0;
                m_pos  <= 64'd0;
                m_len  <= baud_i;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("idle_o", idle_o, !m_busy);
            chk("txd_o", txd_o, m_busy ? m_word[m_k] : 1'b1);
            chk("txc_o", txc_o, m_busy && ((m_len - m_pos) > (baud_i >> 1)));
            chk("shift_to", shift_to, m_busy && (m_pos == m_len));
        end
    end

    // Strobe-clocked receiver: samples txd_o on each rising txc_o, shifting in at the top.
    logic [63:0] rx_sr = 64'd0;
    logic        txc_prev = 1'b0;
    always @(negedge clk) begin
        if (txc_o && !txc_prev) rx_sr <= {txd_o, rx_sr[63:1]};
        txc_prev <= txc_o;
    end

    // Issue a write, then watch the frame until the first idle cycle.
    task automatic run_frame(input logic we, input logic wer, input logic [5:0] bits,
                             input logic [63:0] baud, input logic [63:0] dat,
                             input int chg_at, input logic [63:0] chg_baud,
                             output logic [63:0] got, output int busy_cyc,
                             output int pulses, output int txc_hi);
        bit done;
        bits_i = bits; baud_i = baud; dat_i = dat;
        txreg_we_i = we; txregr_we_i = wer;
        @(posedge clk);
        #1 txreg_we_i = 1'b0; txregr_we_i = 1'b0;
        got = 64'd0; busy_cyc = 0; pulses = 0; txc_hi = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (idle_o) begin
                done = 1;
            end else begin
                if (shift_to && pulses < 64) begin
                    got[pulses] = txd_o;
                    pulses++;
                end
                if (txc_o) txc_hi++;
                busy_cyc++;
                if (busy_cyc == chg_at) #1 baud_i = chg_baud;
                if (busy_cyc > 3000) begin
                    chk("frame_timeout", 64'(busy_cyc), 64'd3000);
                    done = 1;
                end
            end
        end
    endtask

    logic [63:0] got, word;
    int          cyc, pul, hi;

    initial begin
        #1;
        chk("rst_txd", txd_o, 1'b1);
        chk("rst_txc", txc_o, 1'b0);
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_shift", shift_to, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Basic frame 0xA5, 8 bits, B=3
        run_frame(1, 0, 6'd8, 64'd3, 64'hA5, -1, 64'd0, got, cyc, pul, hi);
        chk("basic_bits", got, 64'hA5);
        chk("basic_busy", 64'(cyc), 64'd32);
        chk("basic_pulses", 64'(pul), 64'd8);
        chk("basic_txc_hi", 64'(hi), 64'd16);

        // Reversed load: bits 1,0,0,0
        run_frame(0, 1, 6'd4, 64'd1, 64'h8000_0000_0000_0003, -1, 64'd0, got, cyc, pul, hi);
        chk("rev_bits", got, 64'h1);
        chk("rev_busy", 64'(cyc), 64'd8);
        // Both strobes: straight load wins -> 1,1,0,0
        run_frame(1, 1, 6'd4, 64'd1, 64'h8000_0000_0000_0003, -1, 64'd0, got, cyc, pul, hi);
        chk("both_bits", got, 64'h3);

        // Busy write ignored
        fork
            run_frame(1, 0, 6'd8, 64'd3, 64'hA5, -1, 64'd0, got, cyc, pul, hi);
            begin
                repeat (10) @(posedge clk);
                #2 dat_i = 64'hFF; txreg_we_i = 1'b1;
                @(posedge clk);
                #2 txreg_we_i = 1'b0;
            end
        join
        chk("busywr_bits", got, 64'hA5);
        chk("busywr_busy", 64'(cyc), 64'd32);
        repeat (5) begin
            @(negedge clk);
            chk("busywr_no_extra", idle_o, 1'b1);
        end

        // Zero-length write
        run_frame(1, 0, 6'd0, 64'd3, 64'h0, -1, 64'd0, got, cyc, pul, hi);
        chk("zero_busy", 64'(cyc), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_idle", idle_o, 1'b1);
            chk("zero_txd", txd_o, 1'b1);
        end

        // Live baud: bit 0 keeps 4 cycles, bits 1..3 take 6
        run_frame(1, 0, 6'd4, 64'd3, 64'h5, 1, 64'd5, got, cyc, pul, hi);
        chk("live_busy", 64'(cyc), 64'd22);
        chk("live_bits", got, 64'h5);
        baud_i = 64'd3;

        // Write coinciding with the final shift_to is dropped
        bits_i = 6'd2; baud_i = 64'd1; dat_i = 64'h3; txreg_we_i = 1'b1;
        @(posedge clk);
        #1 txreg_we_i = 1'b0;
        pul = 0;
        for (int i = 0; i < 50 && pul < 2; i++) begin
            @(negedge clk);
            if (shift_to) pul++;
        end
        chk("final_pulses", 64'(pul), 64'd2);
        txreg_we_i = 1'b1; dat_i = 64'h0; bits_i = 6'd4;
        @(posedge clk);
        #1 txreg_we_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("final_drop_idle", idle_o, 1'b1);
        end

        // Loopback, 63-bit frames, B=7, back-to-back on the first idle cycle
        for (int f = 0; f < 5; f++) begin
            word = {$urandom, $urandom};
            run_frame(1, 0, 6'd63, 64'd7, word, -1, 64'd0, got, cyc, pul, hi);
            chk("loop_rx", {1'b0, rx_sr[63:1]}, {1'b0, word[62:0]});
            chk("loop_busy", 64'(cyc), 64'd504);
        end

        // Asynchronous reset mid-frame
        bits_i = 6'd8; baud_i = 64'd3; dat_i = 64'hA5; txreg_we_i = 1'b1;
        @(posedge clk);
        #1 txreg_we_i = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_txd", txd_o, 1'b1);
        chk("arst_txc", txc_o, 1'b0);
        chk("arst_idle", idle_o, 1'b1);
        chk("arst_shift", shift_to, 1'b0);
        @(negedge clk); rst = 1'b0;
        run_frame(1, 0, 6'd8, 64'd2, 64'h5A, -1, 64'd0, got, cyc, pul, hi);
        chk("post_rst_bits", got, 64'h5A);
        chk("post_rst_busy", 64'(cyc), 64'd24);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
